// File: rtl/fourbit_bitloader_pkg.sv
// Shared definitions for the serial-to-4-bit word loader.
package fourbit_bitloader_pkg;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned FILL_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/fourbit_bitloader_bitset.sv
// Combinational single-bit insert: returns word with bit idx replaced by value.
module fourbit_bitset
  import fourbit_bitloader_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        idx,
  input  logic              value,
  output logic [WORD_W-1:0] result
);

  always_comb begin
    result      = word;
    result[idx] = value;
  end

endmodule

// File: rtl/fourbit_bitloader.sv
// Collects four serial bits into a word and holds it until downstream consumes it.
module fourbit_bitloader
  import fourbit_bitloader_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic [WORD_W-1:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FILL_W-1:0] fill
);

  state_t              state, state_next;
  logic [WORD_W-1:0]   word, word_next, word_set;
  logic [FILL_W-1:0]   fill_next;
  logic [1:0]          wr_idx;

  // MSB-first mirrors the index: 3 - fill[1:0].
  assign wr_idx = (MSB_FIRST != 0) ? (2'd3 - fill[1:0]) : fill[1:0];

  fourbit_bitset u_bitset (
    .word   (word),
    .idx    (wr_idx),
    .value  (in_bit),
    .result (word_set)
  );

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign y         = word;

  always_comb begin
    state_next = state;
    word_next  = word;
    fill_next  = fill;
    if (clear) begin
      state_next = FILL;
      word_next  = '0;
      fill_next  = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid) begin
            word_next = word_set;
            fill_next = fill + 3'd1;
            if (fill == 3'd3) state_next = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_next = FILL;
            word_next  = '0;
            fill_next  = '0;
          end
        end
        default: begin
          state_next = FILL;
          word_next  = '0;
          fill_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      word  <= '0;
      fill  <= '0;
    end else begin
      state <= state_next;
      word  <= word_next;
      fill  <= fill_next;
    end
  end

endmodule

// File: doc/fourbit_bitloader.md
FOURBIT_BITLOADER -- requirements
Module: fourbit_bitloader

Interface
REQ-001 Parameter: MSB_FIRST, default 0, bit order (0: first bit to index 0; 1: first bit to index 3).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 clear  input  1  synchronous discard of current word, active-high.
REQ-005 in_valid  input  1  in_bit carries a valid serial bit.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 in_ready  output  1  block accepts in_bit this cycle.
REQ-008 y  output  4  assembled word; valid only while out_valid=1.
REQ-009 out_valid  output  1  complete 4-bit word held on y.
REQ-010 out_ready  input  1  downstream consumes word this cycle.
REQ-011 fill  output  3  bits in current word, 0..4.

Function
REQ-012 Two states SHALL exist: FILL (collecting) and HOLD (word presented).
REQ-013 in_ready SHALL be 1 in FILL and 0 in HOLD, decoded from registered state only.
REQ-014 out_valid SHALL be 1 in HOLD and 0 in FILL, decoded from registered state only.
REQ-015 Bit accept SHALL occur on a rising edge with in_valid=1, in_ready=1, clear=0, rst_n=1.
REQ-016 On accept, word register SHALL update to the bitset of the current word at write index with value in_bit; fill increments by 1.
REQ-017 Write index SHALL be fill[1:0] when MSB_FIRST=0 and 3-fill[1:0] when MSB_FIRST=1.
REQ-018 Accept with fill=3 SHALL move to HOLD with fill=4; out_valid rises the cycle after the 4th accept (latency 1 cycle).
REQ-019 In HOLD, y and fill SHALL stay stable regardless of in_valid/in_bit; no bits are accepted.
REQ-020 In HOLD with out_ready=1 at an edge, SHALL move to FILL, word register to 4'b0000, fill to 0; the first new bit is accepted no earlier than the following edge.
REQ-021 out_ready in FILL SHALL be ignored.
REQ-022 In FILL, y SHALL show the partially built word, unwritten bits 0.
REQ-023 clear=1 at an edge SHALL force FILL, word 4'b0000, fill 0 in any state, overriding accept and out_ready in the same cycle; a held word is dropped.
REQ-024 fill SHALL never exceed 4 and never wrap.

Reset
REQ-025 rst_n=0 at a rising edge SHALL set state FILL, y=4'b0000, fill=0, out_valid=0, in_ready=1 (after that edge), overriding clear and all handshakes.
REQ-026 Reset mid-word or mid-HOLD SHALL discard all data with no partial word emitted.

Structure
REQ-027 State encoding (FILL, HOLD) and word width constant 4 SHALL live in the shared package.
REQ-028 Bit insertion SHALL instantiate the existing fourbit_bitset as the single sub-module; no other sub-modules.
REQ-029 Registers: word (4), fill (3), state (1); no combinational path from in_valid or out_ready to in_ready or out_valid.

Verification
REQ-030 MSB_FIRST=0, bits 1,0,1,1 on consecutive cycles -> next cycle out_valid=1, y=4'b1101, fill=4, in_ready=0.
REQ-031 MSB_FIRST=1, bits 1,0,1,1 -> y=4'b1011 with out_valid=1.
REQ-032 Word held, out_ready=0 for 5 cycles, in_valid=1 in_bit=0 -> y unchanged, fill=4; then out_ready=1 -> next cycle out_valid=0, fill=0, y=4'b0000.
REQ-033 in_valid pattern 1,0,1,0,1,0,1 with bits 1,x,1,x,0,x,1 (MSB_FIRST=0) -> only 4 accepts, y=4'b1011, out_valid after 7th cycle.
REQ-034 Two bits accepted, then clear=1 with in_valid=1 -> fill=0, y=0, bit not taken; next 4 bits 0,1,1,0 -> y=4'b0110.
REQ-035 rst_n=0 during HOLD with out_ready=1 and clear=1 -> out_valid=0, y=0, fill=0, in_ready=1 after that edge.
